// File: rtl/ldpc_ctrl_pkg.sv
// Shared types and sizing helpers for the LDPC iteration scheduler.
package ldpc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CN    = 3'd2,
    ST_VN    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int DEFAULT_MAX_ITER = 16;

  // Counter must represent 0..max_iter inclusive.
  function automatic int iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  function automatic int timer_w(input int load_cycles, input int cn_lat, input int vn_lat);
    int m;
    m = load_cycles;
    if (cn_lat > m) m = cn_lat;
    if (vn_lat > m) m = vn_lat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ldpc_phase_timer.sv
// Loadable down-counter that times each decoder phase; zero_o marks the last phase cycle.
module ldpc_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration scheduler for the flooding LDPC decoder: LOAD -> (CN -> VN -> CHECK)* -> DONE,
// with early exit on zero syndrome, iteration cap, abort, and valid/ready result hand-off.
module ldpc_iter_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int MAX_ITER    = DEFAULT_MAX_ITER,
  parameter int ITER_W      = iter_w(MAX_ITER),
  parameter int LOAD_CYCLES = 1,
  parameter int CN_LAT      = 1,
  parameter int VN_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_zero,
  input  logic              out_ready,
  output logic              busy,
  output logic              llr_load,
  output logic              vn_clr,
  output logic              cn_en,
  output logic              vn_en,
  output logic [ITER_W-1:0] iter_count,
  output logic              out_valid,
  output logic              success
);

  localparam int              TMR_W    = timer_w(LOAD_CYCLES, CN_LAT, VN_LAT);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_e             state_q, state_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               success_q, success_d;
  logic               abort_clr_q, abort_clr_d;
  logic               busy_w;
  logic               tmr_load, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  assign busy_w = (state_q == ST_LOAD) || (state_q == ST_CN) ||
                  (state_q == ST_VN)   || (state_q == ST_CHECK);

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    success_d   = success_q;
    abort_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_LOAD;
        iter_d    = '0;
        success_d = 1'b0;
      end
      ST_LOAD: if (tmr_zero) state_d = ST_CN;
      ST_CN:   if (tmr_zero) state_d = ST_VN;
      ST_VN:   if (tmr_zero) begin
        state_d = ST_CHECK;
        if (iter_q != ITER_MAX) iter_d = iter_q + ITER_W'(1);
      end
      ST_CHECK: begin
        if (syndrome_zero) begin
          state_d   = ST_DONE;
          success_d = 1'b1;
        end else if (iter_q == ITER_MAX) begin
          state_d   = ST_DONE;
          success_d = 1'b0;
        end else begin
          state_d = ST_CN;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any phase exit or CHECK decision taken above.
    if (busy_w && abort) begin
      state_d     = ST_IDLE;
      iter_d      = iter_q;
      success_d   = 1'b0;
      abort_clr_d = 1'b1;
    end
  end

  // Timer is reloaded on every state change; untimed states load zero.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_LOAD: tmr_val = TMR_W'(LOAD_CYCLES - 1);
      ST_CN:   tmr_val = TMR_W'(CN_LAT - 1);
      ST_VN:   tmr_val = TMR_W'(VN_LAT - 1);
      default: tmr_val = '0;
    endcase
  end

  ldpc_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      success_q   <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      success_q   <= success_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  assign busy       = busy_w;
  assign llr_load   = (state_q == ST_LOAD);
  assign vn_clr     = (state_q == ST_LOAD) || abort_clr_q;
  assign cn_en      = (state_q == ST_CN);
  assign vn_en      = (state_q == ST_VN);
  assign out_valid  = (state_q == ST_DONE);
  assign iter_count = iter_q;
  assign success    = success_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl with MAX_ITER=4, LOAD_CYCLES=3, CN_LAT=2, VN_LAT=1.
module tb_ldpc_iter_ctrl;

  localparam int MAX_ITER    = 4;
  localparam int ITER_W      = 3;
  localparam int LOAD_CYCLES = 3;
  localparam int CN_LAT      = 2;
  localparam int VN_LAT      = 1;
  localparam int ITER_CYC    = CN_LAT + VN_LAT + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              syndrome_zero = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, llr_load, vn_clr, cn_en, vn_en, out_valid, success;
  logic [ITER_W-1:0] iter_count;

  int checks   = 0;
  int failures = 0;

  ldpc_iter_ctrl #(
    .MAX_ITER    (MAX_ITER),
    .ITER_W      (ITER_W),
    .LOAD_CYCLES (LOAD_CYCLES),
    .CN_LAT      (CN_LAT),
    .VN_LAT      (VN_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .syndrome_zero (syndrome_zero),
    .out_ready     (out_ready),
    .busy          (busy),
    .llr_load      (llr_load),
    .vn_clr        (vn_clr),
    .cn_en         (cn_en),
    .vn_en         (vn_en),
    .iter_count    (iter_count),
    .out_valid     (out_valid),
    .success       (success)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       syn;
    logic       ready;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    int iter;
    bit succ;
    int cycle;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {busy, llr_load, vn_clr, cn_en, vn_en, out_valid, iter_count, success};
  endfunction

  function automatic logic [9:0] mk(input bit b, input bit l, input bit c, input bit cn,
                                    input bit vn, input bit v, input int it, input bit s);
    logic [2:0] it3;
    it3 = it[2:0];
    return {b, l, c, cn, vn, v, it3, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one decode; syndrome_zero is driven high from cycle syn_cycle onward.
  task automatic run_decode(input int syn_cycle, input int exp_iter, input bit exp_succ,
                            input int hold);
    exp_t e, got;
    int   cyc;
    bit   overlap;
    logic [ITER_W-1:0] it_hold;
    logic              s_hold;
    e.iter  = exp_iter;
    e.succ  = exp_succ;
    e.cycle = LOAD_CYCLES + exp_iter * ITER_CYC + 1;
    sb_q.push_back(e);
    overlap       = 1'b0;
    syndrome_zero = 1'b0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!out_valid && cyc < 60) begin
      if ((int'(llr_load) + int'(cn_en) + int'(vn_en)) > 1) overlap = 1'b1;
      syndrome_zero = (cyc >= syn_cycle);
      tick();
      cyc++;
    end
    syndrome_zero = 1'b0;
    got = sb_q.pop_front();
    check("enables_exclusive", overlap, 0);
    check("done_reached", out_valid, 1);
    check("done_cycle", cyc, got.cycle);
    check("done_iter", iter_count, got.iter);
    check("done_success", success, got.succ);
    it_hold = iter_count;
    s_hold  = success;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      start     = (i == 2);
      tick();
      check($sformatf("hold%0d", i), {out_valid, busy, iter_count, success},
            {1'b1, 1'b0, ITER_W'(got.iter), got.succ});
    end
    start     = (hold > 0);
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("release_idle", {busy, out_valid, iter_count, success}, {2'b00, it_hold, s_hold});
    tick();
    check("still_idle", {busy, out_valid}, 0);
  endtask

  initial begin
    int  cyc;
    bit  saw_valid;

    // Scenario: converge on first CHECK, then DONE with start ignored.
    vecs[0]  = '{1, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[2]  = '{0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[3]  = '{0, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0, 0)};
    vecs[4]  = '{0, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{0, 0, 1, 0, mk(1, 0, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 1, 0)};
    vecs[7]  = '{0, 0, 1, 0, mk(0, 0, 0, 0, 0, 1, 1, 1)};
    vecs[8]  = '{1, 1, 1, 0, mk(0, 0, 0, 0, 0, 1, 1, 1)};
    vecs[9]  = '{1, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[10] = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1)};

    tick();
    tick();
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", outs(), 0);

    for (int i = 0; i < 11; i++) begin
      start         = vecs[i].start;
      abort         = vecs[i].abort;
      syndrome_zero = vecs[i].syn;
      out_ready     = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    start = 0; abort = 0; syndrome_zero = 0; out_ready = 0;

    run_decode(1000, MAX_ITER, 0, 0);  // never converges: cap at MAX_ITER
    run_decode(15, 3, 1, 5);           // converges at third CHECK, held in DONE
    run_decode(19, MAX_ITER, 1, 0);    // converges on the final CHECK: success wins

    // Abort during vn_en of iteration 2 (cycle 10).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) tick();
    check("pre_abort_vn", {vn_en, iter_count}, {1'b1, ITER_W'(1)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, vn_clr, out_valid, success}, 4'b0100);
    tick();
    check("abort_clr_once", {busy, vn_clr}, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", saw_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_load", outs(), mk(1, 1, 1, 0, 0, 0, 0, 0));

    // Reset during second cn_en cycle of iteration 2 (cycle 9).
    for (cyc = 1; cyc < 9; cyc++) tick();
    check("pre_reset_cn", {cn_en, iter_count}, {1'b1, ITER_W'(1)});
    rst = 1'b1;
    tick();
    check("reset_mid_decode", outs(), 0);
    rst = 1'b0;
    tick();
    check("idle_after_mid_reset", outs(), 0);

    // Reset while holding a successful result in DONE.
    syndrome_zero = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < 8; cyc++) tick();
    check("done_before_reset", outs(), mk(0, 0, 0, 0, 0, 1, 1, 1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    syndrome_zero = 1'b0;
    check("reset_from_done", outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
Iteration scheduler for the flooding LDPC decoder. Sequences the variable-node and check-node arrays through LLR load, check-node update, variable-node update and syndrome check phases. Stops early when the syndrome is zero, or after MAX_ITER iterations. Presents the result through a valid/ready handshake to the downstream hard-decision reader.

Parameters:
MAX_ITER, 16, maximum decoding iterations (>=1)
ITER_W, 5, width of iteration counter; must hold MAX_ITER
LOAD_CYCLES, 1, cycles llr_load is held (>=1)
CN_LAT, 1, cycles cn_en is held per iteration (>=1)
VN_LAT, 1, cycles vn_en is held per iteration (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  begin a decode; sampled only in IDLE
abort  input  1  cancel the decode in progress; ignored in IDLE and DONE
syndrome_zero  input  1  all parity checks satisfied (from the check-node array); sampled only in CHECK
out_ready  input  1  downstream accepts result
busy  output  1  high in LOAD/CN/VN/CHECK
llr_load  output  1  channel LLR register write enable
vn_clr  output  1  drives the VarNode rst pins; clears the Q registers
cn_en  output  1  check-node array update enable
vn_en  output  1  variable-node array update enable
iter_count  output  ITER_W  number of completed iterations
out_valid  output  1  result (x bits, iter_count, success) is valid
success  output  1  decode converged; meaningful only while out_valid=1

Behaviour:
- Moore FSM. All outputs are decoded from registered state and counters. No combinational input-to-output paths.
- States: IDLE, LOAD, CN, VN, CHECK, DONE.
- Phase timer: a down-counter loaded on every phase entry; the phase exits when the counter reaches 0.
- Reset (rst=1 at an edge): state=IDLE, timer=0, iter_count=0, success=0, all other outputs 0. Reset takes precedence over all other inputs. A reset mid-decode leaves no residual state.
- IDLE:
  - start=1 -> LOAD.
  - iter_count and success keep their values from the last decode.
- LOAD:
  - llr_load=1 and vn_clr=1 for LOAD_CYCLES cycles.
  - iter_count is cleared on entry.
  - Then -> CN.
- CN: cn_en=1 for CN_LAT cycles, then -> VN.
- VN:
  - vn_en=1 for VN_LAT cycles, then -> CHECK.
  - iter_count increments on the VN->CHECK edge.
- CHECK (1 cycle), in priority order:
  - syndrome_zero=1 -> DONE with success=1.
  - else iter_count==MAX_ITER -> DONE with success=0.
  - else -> CN.
- DONE:
  - out_valid=1; iter_count and success are held stable.
  - out_ready=1 -> IDLE next cycle.
  - start is ignored, including when it arrives in the same cycle as out_ready. A new start is accepted from IDLE only.
- abort=1 in LOAD/CN/VN/CHECK:
  - Next state is IDLE; vn_clr=1 for one cycle on that transition.
  - success=0; out_valid is never raised.
  - abort has priority over phase-exit and CHECK decisions in the same cycle.
- Cycle timing (start sampled at edge 0):
  - LOAD occupies cycles 1..LOAD_CYCLES.
  - Each iteration takes CN_LAT+VN_LAT+1 cycles.
  - Total decode cycles before DONE = LOAD_CYCLES + k*(CN_LAT+VN_LAT+1), where k = number of iterations run.
- Only one of llr_load, cn_en, vn_en is high in any cycle.
- iter_count never exceeds MAX_ITER and does not wrap.

Decomposition:
- Shared package ldpc_ctrl_pkg:
  - state encoding (3-bit enum, IDLE=0)
  - default MAX_ITER
  - ITER_W derivation function (clog2(MAX_ITER+1))
- One natural sub-module: ldpc_phase_timer.
  - Loadable down-counter with load value and zero flag.
  - Width = clog2 of max(LOAD_CYCLES, CN_LAT, VN_LAT).
  - The FSM instantiates one copy.

Test Plan:
All scenarios use MAX_ITER=4, LOAD_CYCLES=3, CN_LAT=2, VN_LAT=1.
1. start at cycle 0, syndrome_zero=1 -> llr_load cycles 1-3, cn_en 4-5, vn_en 6, CHECK 7; out_valid from cycle 8 with iter_count=1, success=1.
2. syndrome_zero held 0 -> 4 iterations, out_valid at cycle 20 with iter_count=4, success=0; cn_en and vn_en never high simultaneously.
3. In DONE, out_ready=0 for 5 cycles and start pulsed -> out_valid, iter_count and success stable; start ignored; out_ready=1 -> IDLE next cycle, busy=0.
4. abort during vn_en of iteration 2 -> next cycle IDLE with vn_clr=1 for exactly 1 cycle; out_valid stays 0; a new start then runs from LOAD with iter_count cleared.
5. rst=1 during the second cn_en cycle -> all outputs 0 at the following edge; iter_count=0; state IDLE.
6. start with syndrome_zero rising only at the third CHECK -> out_valid with iter_count=3, success=1, at cycle 16.
